iwrite_back_ext: RTL
====================

# iwrite_back_ext

Parametrised write-back stage for the pipelined ARM-style core. It sits after the memory stage and registers the memory/ALU results and PC for one cycle. It selects the register-file write value from ALU result, load data or link address (PC + step), and aligns and sign- or zero-extends byte and halfword loads. It also adds valid/stall/flush pipeline control and a retired-instruction counter.

## Interface
- WIDTH, 32: datapath width in bits; multiple of 8, at least 32.
- REG_ADDR_W, 5: register index width.
- PC_STEP, 4: link-address increment added to the registered PC.
- CNT_W, 32: retired-counter width.

- iw_clk  in  1  stage clock; all state updates on rising edge.
- iw_rst_n  in  1  reset, synchronous, active-low.
- valid_in  in  1  an instruction is presented from the memory stage.
- stall  in  1  hold the current stage contents.
- flush  in  1  squash: stage becomes empty.
- read_data  in  WIDTH  raw data word from data memory.
- alu_result  in  WIDTH  ALU result; its low bits are also the load byte offset.
- pc_in  in  WIDTH  PC of the incoming instruction.
- write_register_in  in  REG_ADDR_W  destination register.
- reg_write_in  in  1  instruction writes the register file.
- wb_sel  in  2  00 ALU, 01 load data, 10 link (pc + PC_STEP), 11 treated as ALU.
- mem_size  in  2  00 byte, 01 halfword, 10/11 full word.
- mem_signed  in  1  1 = sign-extend sub-word loads, 0 = zero-extend.
- valid_out  out  1  stage holds a live instruction.
- pc_out  out  WIDTH  registered PC.
- write_register_out  out  REG_ADDR_W  registered destination.
- reg_write_out  out  1  registered reg_write_in AND valid_out.
- write_data  out  WIDTH  selected and extended write-back value.
- retired_count  out  CNT_W  number of instructions retired.

## Operation
- Stage register holds: valid, pc, write_register, reg_write, read_data, alu_result, wb_sel, mem_size, mem_signed.
- Priority at each edge is reset > flush > stall > load.
  - Reset: every field is cleared.
  - Flush: valid is cleared; the other fields may keep their values but must not be visible through reg_write_out.
  - Stall (no flush): all fields hold.
  - Otherwise: all fields load from the inputs, and valid loads valid_in.
- write_data is combinational from the registered fields only.
  - ALU: alu_result_r.
  - Link: pc_r + PC_STEP, modulo 2^WIDTH.
  - Load, byte: select lane alu_result_r[log2(WIDTH/8)-1:0]; extend bit 7 if mem_signed, else zero-fill.
  - Load, halfword: select the halfword lane from the offset with bit 0 ignored (misaligned halfwords are silently aligned down); extend bit 15 or zero-fill.
  - Load, word: full read_data_r.
- Retire event: valid_r = 1, stall = 0 and flush = 0 at a rising edge. retired_count increments by 1 on each retire event and wraps from 2^CNT_W-1 to 0.
  - A flushed live instruction is not counted.
  - A stalled instruction is counted once, on the edge it leaves.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- write_data settles within the same cycle as the registered fields; no extra register.
- Reset values: valid_out 0, pc_out 0, write_register_out 0, reg_write_out 0, write_data 0 (ALU select with zero result), retired_count 0.
- Reset asserted mid-stall or mid-flush overrides both.
- Stall and flush asserted together: flush wins, and the stage becomes empty on that edge.
- valid_in = 0 while not stalled loads a bubble; that bubble's reg_write_out is 0 whatever reg_write_in was.

## Test plan
- Reset: hold iw_rst_n = 0 for 2 cycles with random inputs -> all outputs 0; release -> retired_count stays 0 until the first retire event.
- ALU and link select: pc_in = 0x0000_1000, wb_sel = 10, valid_in = 1 -> write_data = 0x0000_1004 one cycle later. Then wb_sel = 00, alu_result = 0xDEAD_BEEF -> write_data = 0xDEAD_BEEF.
- Load extension with read_data = 0x80FF_7F01 (WIDTH = 32):
  - byte, offset 3, signed -> 0xFFFF_FF80.
  - byte, offset 2, unsigned -> 0x0000_00FF.
  - halfword, offset 3, signed -> 0xFFFF_80FF.
  - halfword, offset 0, unsigned -> 0x0000_7F01.
- Stall: load a valid instruction, assert stall for 3 cycles while the inputs change -> outputs hold and retired_count does not change. Deassert stall -> next instruction loads and retired_count increments by 1.
- Flush: a valid instruction with reg_write_in = 1 is in the stage; assert flush together with stall -> next cycle valid_out = 0, reg_write_out = 0, retired_count unchanged.
- Counter wrap: CNT_W = 4, retire 17 consecutive valid instructions -> retired_count reads 1.

Source files
------------

// File: rtl/iwrite_back_ext.sv
// ---------------------------------------------------------------------------
// iwrite_back_ext
//
// Write-back stage of the pipelined ARM-style core. Registers the memory-stage
// results for one cycle, then picks the register-file write value from the
// ALU result, the load data (lane-selected and sign/zero-extended) or the
// link address (pc + PC_STEP). Adds valid/stall/flush control and a counter of
// retired instructions.
//
// Parameters
//   WIDTH       datapath width, multiple of 8, >= 32
//   REG_ADDR_W  register index width
//   PC_STEP     link-address increment
//   CNT_W       retired-counter width
//
// Ports
//   iw_clk, iw_rst_n    clock, synchronous active-low reset
//   valid_in            instruction presented by the memory stage
//   stall               hold stage contents
//   flush               squash stage contents (wins over stall)
//   read_data           raw data-memory word
//   alu_result          ALU result; low bits double as load byte offset
//   pc_in               PC of incoming instruction
//   write_register_in   destination register
//   reg_write_in        instruction writes the register file
//   wb_sel              00 ALU, 01 load, 10 link, 11 ALU
//   mem_size            00 byte, 01 halfword, 1x word
//   mem_signed          sign-extend sub-word loads
//   valid_out           stage holds a live instruction
//   pc_out              registered PC
//   write_register_out  registered destination
//   reg_write_out       registered reg_write gated by valid
//   write_data          selected, extended write-back value
//   retired_count       retired instructions, wraps at 2^CNT_W
// ---------------------------------------------------------------------------
module iwrite_back_ext #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5,
    parameter int PC_STEP    = 4,
    parameter int CNT_W      = 32
) (
    input  logic                  iw_clk,
    input  logic                  iw_rst_n,
    input  logic                  valid_in,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      read_data,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic [WIDTH-1:0]      pc_in,
    input  logic [REG_ADDR_W-1:0] write_register_in,
    input  logic                  reg_write_in,
    input  logic [1:0]            wb_sel,
    input  logic [1:0]            mem_size,
    input  logic                  mem_signed,
    output logic                  valid_out,
    output logic [WIDTH-1:0]      pc_out,
    output logic [REG_ADDR_W-1:0] write_register_out,
    output logic                  reg_write_out,
    output logic [WIDTH-1:0]      write_data,
    output logic [CNT_W-1:0]      retired_count
);

    // Number of address bits needed to pick a byte lane within one word.
    localparam int OFF_W = $clog2(WIDTH / 8);

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_LINK = 2'b10,
        WB_ALT  = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_WALT = 2'b11
    } mem_size_e;

    typedef struct packed {
        logic                  valid;
        logic [WIDTH-1:0]      pc;
        logic [REG_ADDR_W-1:0] write_register;
        logic                  reg_write;
        logic [WIDTH-1:0]      read_data;
        logic [WIDTH-1:0]      alu_result;
        wb_sel_e               wb_sel;
        mem_size_e             mem_size;
        logic                  mem_signed;
    } stage_t;

    stage_t           stage_r;
    logic [CNT_W-1:0] count_r;
    logic             retire;

    // An instruction retires on the edge it leaves the stage alive.
    assign retire = stage_r.valid & ~stall & ~flush;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            stage_r <= '0;
        end else if (flush) begin
            // Only valid is cleared; stale fields are masked by valid.
            stage_r.valid <= 1'b0;
        end else if (!stall) begin
            stage_r.valid          <= valid_in;
            stage_r.pc             <= pc_in;
            stage_r.write_register <= write_register_in;
            stage_r.reg_write      <= reg_write_in;
            stage_r.read_data      <= read_data;
            stage_r.alu_result     <= alu_result;
            stage_r.wb_sel         <= wb_sel_e'(wb_sel);
            stage_r.mem_size       <= mem_size_e'(mem_size);
            stage_r.mem_signed     <= mem_signed;
        end
    end

    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            count_r <= '0;
        end else if (retire) begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    // Load alignment: shift the addressed lane down to bit 0. Halfwords
    // ignore offset bit 0, which aligns misaligned accesses down.
    logic [OFF_W-1:0] byte_off;
    logic [OFF_W-1:0] half_off;
    logic [WIDTH-1:0] byte_shifted;
    logic [WIDTH-1:0] half_shifted;
    logic [7:0]       byte_lane;
    logic [15:0]      half_lane;
    logic [WIDTH-1:0] load_value;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statements can infer a latch.
        load_value   = stage_r.read_data;
        byte_off     = stage_r.alu_result[OFF_W-1:0];
        half_off     = {byte_off[OFF_W-1:1], 1'b0};
        byte_shifted = stage_r.read_data >> {byte_off, 3'b000};
        half_shifted = stage_r.read_data >> {half_off, 3'b000};
        byte_lane    = byte_shifted[7:0];
        half_lane    = half_shifted[15:0];

        case (stage_r.mem_size)
            SZ_BYTE: load_value = {{(WIDTH-8){stage_r.mem_signed & byte_lane[7]}}, byte_lane};
            SZ_HALF: load_value = {{(WIDTH-16){stage_r.mem_signed & half_lane[15]}}, half_lane};
            default: load_value = stage_r.read_data;
        endcase
    end

    always_comb begin
        write_data = stage_r.alu_result;
        case (stage_r.wb_sel)
            WB_LOAD: write_data = load_value;
            WB_LINK: write_data = stage_r.pc + WIDTH'(PC_STEP);
            default: write_data = stage_r.alu_result;
        endcase
    end

    assign valid_out          = stage_r.valid;
    assign pc_out             = stage_r.pc;
    assign write_register_out = stage_r.write_register;
    assign reg_write_out      = stage_r.reg_write & stage_r.valid;
    assign retired_count      = count_r;

endmodule
